// File: rtl/key_conditioner.sv
// key_conditioner: debounces two raw keys and turns accepted presses
// into one-cycle zero/one pulses, or a single conflict pulse when a
// press is rejected.
//
// Optional build macro: KEY_SYNC_EN (adds a two-flop input synchronizer
// per key; press-to-pulse latency grows by two edges).
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-low reset
//   btn_zero  in   raw "0" key, high = pressed
//   btn_one   in   raw "1" key, high = pressed
//   zero      out  one-cycle pulse per accepted "0" press
//   one       out  one-cycle pulse per accepted "1" press
//   conflict  out  one-cycle pulse when a press is rejected
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_zero,
    input  logic btn_one,
    output logic zero,
    output logic one,
    output logic conflict
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        BLOCK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // bit 0 = "0" key, bit 1 = "1" key
    logic [1:0] raw;
    logic [1:0] key_s;

    assign raw = {btn_one, btn_zero};

`ifdef KEY_SYNC_EN
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = sync2_q;
`else
    assign key_s = raw;
`endif

    // ---------------------------------------------------------------
    // Debounce: count consecutive samples that disagree with the
    // accepted level; the sample that would make the count reach
    // DEBOUNCE_CYCLES flips the level instead.
    // ---------------------------------------------------------------
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [1:0][CNT_W-1:0] cnt_d;
    logic [1:0]            lvl_q;
    logic [1:0]            lvl_d;
    logic [1:0]            lvl_prev_q;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            lvl_d[k] = lvl_q[k];
            cnt_d[k] = '0;
            if (key_s[k] != lvl_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    lvl_d[k] = ~lvl_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
        end
    end

    // Rising edge of the accepted level, one edge after it toggled,
    // so the registered pulse lands one edge later still.
    logic [1:0] rise;
    logic       none_held;

    assign rise      = lvl_q & ~lvl_prev_q;
    assign none_held = (lvl_q == 2'b00);

    // ---------------------------------------------------------------
    // Press arbitration FSM
    // ---------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   zero_q, zero_d;
    logic   one_q, one_d;
    logic   conflict_q, conflict_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            zero_q     <= 1'b0;
            one_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            zero_q     <= zero_d;
            one_q      <= one_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rise == 2'b11) begin
                    state_d = BLOCK;
                end else if (rise != 2'b00) begin
                    state_d = HELD;
                end
            end
            HELD: begin
                // Only the other key can rise while one is held.
                if (none_held) begin
                    state_d = IDLE;
                end else if (rise != 2'b00) begin
                    state_d = BLOCK;
                end
            end
            BLOCK: begin
                if (none_held) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        zero_d     = 1'b0;
        one_d      = 1'b0;
        conflict_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise == 2'b11) begin
                    conflict_d = 1'b1;
                end else if (rise == 2'b01) begin
                    zero_d = 1'b1;
                end else if (rise == 2'b10) begin
                    one_d = 1'b1;
                end
            end
            HELD: begin
                if (!none_held && rise != 2'b00) begin
                    conflict_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign zero     = zero_q;
    assign one      = one_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner: directed vector table, hand sequences
// and randomized key activity checked against a reference model.
module tb_key_conditioner;

    localparam int D = 4;
`ifdef KEY_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    // edge at which the pulse is registered, counting the first
    // edge that sees the press as edge 1
    localparam int LAT = D + 1 + SYNC;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_zero = 1'b0;
    logic btn_one = 1'b0;
    logic zero;
    logic one;
    logic conflict;

    always #5 clk = ~clk;

    key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_zero(btn_zero),
        .btn_one(btn_one),
        .zero(zero),
        .one(one),
        .conflict(conflict)
    );

    int checks = 0;
    int fails = 0;
    int tz = 0;
    int to = 0;
    int tc = 0;

    // ---------------- reference model ----------------
    // A key's accepted level flips once the last D samples all
    // disagree with it; pulses follow one edge after the flip.
    bit hist [2][D];
    bit m_lvl [2];
    bit m_rose [2];
    bit m_sy1 [2];
    bit m_sy2 [2];
    int m_mode;            // 0 free, 1 one key owns, 2 rejected
    logic [2:0] m_out;     // {zero, one, conflict}

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < D; i++) hist[k][i] = 1'b0;
            m_lvl[k]  = 1'b0;
            m_rose[k] = 1'b0;
            m_sy1[k]  = 1'b0;
            m_sy2[k]  = 1'b0;
        end
        m_mode = 0;
        m_out  = 3'b000;
    endfunction

    function automatic void model_edge(bit rz, bit ro);
        bit raw [2];
        bit samp [2];
        bit both_low;
        bit all_opp;
        raw = '{rz, ro};
        if (SYNC != 0) begin
            samp  = m_sy2;
            m_sy2 = m_sy1;
            m_sy1 = raw;
        end else begin
            samp = raw;
        end
        m_out = 3'b000;
        both_low = !m_lvl[0] && !m_lvl[1];
        case (m_mode)
            0: begin
                if (m_rose[0] && m_rose[1]) begin
                    m_out = 3'b001; m_mode = 2;
                end else if (m_rose[0]) begin
                    m_out = 3'b100; m_mode = 1;
                end else if (m_rose[1]) begin
                    m_out = 3'b010; m_mode = 1;
                end
            end
            1: begin
                if (both_low) m_mode = 0;
                else if (m_rose[0] || m_rose[1]) begin
                    m_out = 3'b001; m_mode = 2;
                end
            end
            default: begin
                if (both_low) m_mode = 0;
            end
        endcase
        for (int k = 0; k < 2; k++) begin
            for (int i = D - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = samp[k];
            all_opp = 1'b1;
            for (int i = 0; i < D; i++)
                if (hist[k][i] == m_lvl[k]) all_opp = 1'b0;
            m_rose[k] = 1'b0;
            if (all_opp) begin
                m_lvl[k]  = !m_lvl[k];
                m_rose[k] = m_lvl[k];
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [2:0] exp);
        checks++;
        if ({zero, one, conflict} !== exp) begin
            fails++;
            $display("FAIL %s: got zero/one/conflict=%b expected %b at %0t",
                     tag, {zero, one, conflict}, exp, $time);
        end
    endtask

    task automatic check_cnt(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d pulses expected %0d", tag, got, want);
        end
    endtask

    task automatic drive(input bit z, input bit o);
        btn_zero = z;
        btn_one  = o;
        @(posedge clk);
        model_edge(z, o);
        @(negedge clk);
        tz += int'(zero);
        to += int'(one);
        tc += int'(conflict);
    endtask

    task automatic run(input bit z, input bit o, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(z, o);
            check(tag, m_out);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check("async_reset", 3'b000);
        @(posedge clk);
        @(negedge clk);
        check("in_reset", 3'b000);
        reset = 1'b1;
    endtask

    task automatic clr_tally();
        tz = 0; to = 0; tc = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         bz;
        bit         bo;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit z, bit o, int hold, int len,
                                int at, logic [2:0] pv);
        vec_t v;
        for (int i = 0; i < len; i++) begin
            v.bz  = z && (i < hold);
            v.bo  = o && (i < hold);
            v.exp = (i == at) ? pv : 3'b000;
            tbl.push_back(v);
        end
    endfunction

    initial begin
        vec_t v;
        int seg;
        bit rz, ro;

        add(1, 0, 20, 30, LAT - 1, 3'b100);  // clean "0" press
        add(0, 1, D - 1, 12, -1, 3'b000);    // glitch one short
        add(0, 1, D, 14, LAT - 1, 3'b010);   // exactly D samples
        for (int i = 0; i < 30; i++) begin    // bouncing "1" key
            v.bz = 1'b0;
            v.bo = (i % 2) == 0;
            v.exp = 3'b000;
            tbl.push_back(v);
        end
        add(0, 0, 0, 8, -1, 3'b000);

        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].bz, tbl[i].bo);
            check("table", tbl[i].exp);
        end

        // simultaneous press -> single conflict, then back to idle
        do_reset();
        clr_tally();
        run(1, 1, 10, "both_press");
        run(0, 0, 6, "both_release");
        check_cnt("both_conflict", tc, 1);
        check_cnt("both_zero", tz, 0);
        check_cnt("both_one", to, 0);
        clr_tally();
        run(1, 0, 8, "after_block_press");
        run(0, 0, 8, "after_block_release");
        check_cnt("idle_again_zero", tz, 1);

        // "0" held, "1" joins later
        do_reset();
        clr_tally();
        run(1, 0, 8, "held_zero");
        run(1, 1, 12, "held_both");
        run(0, 0, 8, "held_release");
        check_cnt("held_zero_cnt", tz, 1);
        check_cnt("held_one_cnt", to, 0);
        check_cnt("held_conflict_cnt", tc, 1);

        // reset in mid-debounce, key kept high through release
        do_reset();
        clr_tally();
        run(0, 1, 3, "pre_reset");
        do_reset();
        run(0, 1, LAT - 1, "post_reset_wait");
        check_cnt("post_reset_early", to, 0);
        run(0, 1, 6 + SYNC - (LAT - 1), "post_reset_hold");
        run(0, 0, 8, "post_reset_release");
        check_cnt("post_reset_one", to, 1);
        check_cnt("post_reset_conflict", tc, 0);

        // randomized key activity with occasional reset
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            rz  = 1'($urandom_range(0, 1));
            ro  = 1'($urandom_range(0, 1));
            seg = $urandom_range(1, 2 * D + 2);
            run(rz, ro, seg, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive clk cycles a raw level must hold before it is accepted; legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 16, meaning debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port btn_zero, input, 1 bit: raw, bouncing "0" key, high = pressed.
REQ-006 SHALL have port btn_one, input, 1 bit: raw, bouncing "1" key, high = pressed.
REQ-007 SHALL have port zero, output, 1 bit: one-cycle pulse per accepted "0" press; drives the sequence detector's zero input.
REQ-008 SHALL have port one, output, 1 bit: one-cycle pulse per accepted "1" press; drives the sequence detector's one input.
REQ-009 SHALL have port conflict, output, 1 bit: one-cycle pulse when a press is rejected.

Function
REQ-010 SHALL keep, per key, a registered debounced level and a CNT_W-bit counter.
REQ-011 SHALL clear a key's counter in any cycle its sampled input equals its debounced level.
REQ-012 SHALL increment the counter while the sampled input differs; on the edge where it would reach DEBOUNCE_CYCLES, SHALL toggle the debounced level and clear the counter.
REQ-013 SHALL therefore accept a level held for DEBOUNCE_CYCLES consecutive sampled edges; any shorter glitch SHALL leave the debounced level unchanged.
REQ-014 SHALL run a 3-state FSM: IDLE (no key held), HELD (exactly one accepted key held), BLOCK (rejected press in progress).
REQ-015 IDLE: debounced rising edge on exactly one key -> pulse zero or one for one cycle, go HELD.
REQ-016 IDLE: debounced rising edges on both keys in the same cycle -> pulse conflict only, go BLOCK.
REQ-017 HELD: debounced rising edge on the other key -> pulse conflict, go BLOCK; no zero/one pulse.
REQ-018 HELD or BLOCK: both debounced levels low -> go IDLE on the next edge.
REQ-019 BLOCK: SHALL emit no zero/one pulses; a further rising edge SHALL not re-pulse conflict.
REQ-020 Pulse outputs SHALL be registered, asserted exactly one clk cycle, one edge after the debounced level toggles.
REQ-021 zero, one and conflict SHALL be mutually exclusive in every cycle.
REQ-022 Debounced falling edges SHALL generate no pulse.
REQ-023 Without synchronizer (REQ-029), a clean press first sampled at edge 1 SHALL produce a pulse high during the cycle after edge DEBOUNCE_CYCLES+1.

Reset
REQ-024 reset low SHALL asynchronously force FSM to IDLE, both counters to 0, both debounced levels to 0, and zero, one, conflict to 0.
REQ-025 Reset asserted mid-debounce SHALL discard partial count; after release the press SHALL require a full DEBOUNCE_CYCLES again.
REQ-026 A key held through reset release SHALL be treated as a new press and produce one pulse after debounce.
REQ-027 Synchronizer flops (if present) SHALL also reset to 0.

Configuration
REQ-028 Macro KEY_SYNC_EN SHALL select input synchronization.
REQ-029 With KEY_SYNC_EN defined: each raw key SHALL pass a two-flop synchronizer before debounce; press-to-pulse latency becomes DEBOUNCE_CYCLES+3 edges.
REQ-030 Without KEY_SYNC_EN: raw keys SHALL feed debounce logic directly; latency per REQ-023.

Verification (DEBOUNCE_CYCLES=4, KEY_SYNC_EN undefined unless stated)
REQ-031 btn_zero high 20 cycles from edge 1 -> zero high only in the cycle after edge 5; one, conflict stay 0.
REQ-032 btn_one toggling every cycle for 30 cycles, then low -> no pulse on any output.
REQ-033 btn_zero and btn_one rising on the same cycle, held 10 cycles -> conflict pulsed once after edge 5; zero, one never high; FSM IDLE after both released 4 cycles.
REQ-034 btn_zero held, btn_one pressed 8 cycles later -> zero pulse once, then a single conflict pulse; no one pulse.
REQ-035 btn_one high 3 cycles, reset low 1 cycle, btn_one held 6 more -> no pulse before edge 4 after release; one pulse exactly once.
REQ-036 KEY_SYNC_EN defined, btn_zero high from edge 1 -> zero high only in the cycle after edge 7.
